// File: rtl/edge_evt_pkg.sv
// Shared types and defaults for the edge event serializer.
package edge_evt_pkg;

    localparam int unsigned EDGE_WIDTH = 32;
    localparam int unsigned EDGE_IDX_W = $clog2(EDGE_WIDTH);

    typedef enum logic {
        IDLE,
        HOLD
    } evt_state_e;

    typedef logic [EDGE_IDX_W-1:0] edge_idx_t;

endpackage

// File: rtl/edge_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module edge_rr_pick #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]         req_i,
    input  logic [$clog2(WIDTH)-1:0] ptr_i,
    output logic                     any_o,
    output logic [$clog2(WIDTH)-1:0] idx_o
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotate so ptr_i lands at bit 0, then find the lowest set bit.
    always_comb begin
        rot = '0;
        off = '0;
        for (int j = 0; j < WIDTH; j++) begin
            rot[j] = req_i[IDX_W'(IDX_W'(j) + ptr_i)];
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign any_o = |req_i;
    // WIDTH is a power of two, so the IDX_W-bit sum wraps modulo WIDTH.
    assign idx_o = off + ptr_i;

endmodule

// File: rtl/edge_event_serializer.sv
// Serializes sticky edge flags into single-index valid/ready events, round-robin,
// reporting each flag once until it is re-armed.
module edge_event_serializer
    import edge_evt_pkg::*;
#(
    parameter int unsigned WIDTH = EDGE_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           edge_i,
    input  logic [WIDTH-1:0]           rearm_i,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(WIDTH)-1:0]   evt_idx_o,
    output logic [$clog2(WIDTH):0]     pend_cnt_o
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    evt_state_e       state_q, state_d;
    logic [WIDTH-1:0] served_q, served_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;

    logic [WIDTH-1:0] pending;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             fire;

    assign pending = edge_i & ~served_q;

    edge_rr_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .req_i (pending),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // A new event is latched from IDLE, or in HOLD when the current one is accepted.
    assign fire = pick_any && ((state_q == IDLE) || evt_ready_i);

    always_comb begin
        state_d   = state_q;
        served_d  = served_q & ~rearm_i;
        rr_ptr_d  = rr_ptr_q;
        evt_idx_d = evt_idx_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (evt_ready_i && !pick_any) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Setting the served bit after the re-arm clear lets selection win a same-cycle re-arm.
        if (fire) begin
            served_d[pick_idx] = 1'b1;
            rr_ptr_d           = pick_idx + IDX_W'(1);
            evt_idx_d          = pick_idx;
        end
    end

    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pend_cnt_d = pend_cnt_d + CNT_W'(pending[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            served_q   <= '0;
            rr_ptr_q   <= '0;
            evt_idx_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            served_q   <= served_d;
            rr_ptr_q   <= rr_ptr_d;
            evt_idx_q  <= evt_idx_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign evt_valid_o = (state_q == HOLD);
    assign evt_idx_o   = evt_idx_q;
    assign pend_cnt_o  = pend_cnt_q;

endmodule
